// File: rtl/r2sdf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : r2sdf_pkg
//  Description : Shared constants for the radix-2 single-path delay-feedback
//                FFT stage: controller state encoding, trivial-rotation
//                selectors and the counter/twiddle-index width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package r2sdf_pkg;

    // Controller states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RUN1  = 3'd2;
    localparam logic [2:0] ST_RUN0  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    // Trivial rotation selectors, (-j)^k for k mod 4
    localparam logic [1:0] ROT_ONE   = 2'd0;  // x * 1
    localparam logic [1:0] ROT_NEG_J = 2'd1;  // x * -j : (hi, -hr)
    localparam logic [1:0] ROT_NEG_1 = 2'd2;  // x * -1 : (-hr, -hi)
    localparam logic [1:0] ROT_POS_J = 2'd3;  // x * +j : (-hi, hr)

    // Width of the sample counter / twiddle index, never below one bit
    function automatic int r2sdf_cnt_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/r2sdf_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : r2sdf_delay_line
//  Description : Complex shift register of DEPTH entries. Shifts on en,
//                clears asynchronously, and presents the oldest entry.
//  Revision    : 1.0  initial release
// ============================================================================
module r2sdf_delay_line
    import r2sdf_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din_r,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_r,
    output logic [WIDTH-1:0] dout_i
);

    logic [WIDTH-1:0] r_mem_r [DEPTH];
    logic [WIDTH-1:0] r_mem_i [DEPTH];

    // Shift newest sample into tap 0; tap DEPTH-1 holds the oldest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem_r[k] <= '0;
                r_mem_i[k] <= '0;
            end
        end else if (en) begin
            r_mem_r[0] <= din_r;
            r_mem_i[0] <= din_i;
            for (int k = 1; k < DEPTH; k++) begin
                r_mem_r[k] <= r_mem_r[k-1];
                r_mem_i[k] <= r_mem_i[k-1];
            end
        end
    end

    assign dout_r = r_mem_r[DEPTH-1];
    assign dout_i = r_mem_i[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/r2sdf_stage.sv
`default_nettype none
// ============================================================================
//  Module      : r2sdf_stage
//  Description : Radix-2 single-path delay-feedback FFT stage: butterfly,
//                feedback delay line, phase controller, flush/drain and
//                valid/ready handshake. Optional trivial (-j)^k rotation.
//                Build option R2SDF_SCALE_EN: every emitted value x becomes
//                (x+1)>>>1; the delay line keeps unscaled h.
//  Revision    : 1.0  initial release
// ============================================================================
module r2sdf_stage
    import r2sdf_pkg::*;
#(
    parameter int DATA_W   = 15,
    parameter int DELAY    = 16,
    parameter int TRIV_ROT = 0,
    localparam int OUT_W   = DATA_W + 1,
    localparam int CNT_W   = r2sdf_cnt_w(DELAY)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [DATA_W-1:0] din_r,
    input  logic [DATA_W-1:0] din_i,
    input  logic              flush,
    output logic              dout_valid,
    output logic [OUT_W-1:0]  dout_r,
    output logic [OUT_W-1:0]  dout_i,
    output logic [CNT_W-1:0]  tw_idx,
    output logic              busy
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DELAY - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_din_ready;
    logic             r_busy;
    logic             r_dout_valid;
    logic [OUT_W-1:0] r_dout_r;
    logic [OUT_W-1:0] r_dout_i;
    logic [CNT_W-1:0] r_tw_idx;

    logic             w_accept;
    logic             w_adv;
    logic             w_wrap;
    logic [OUT_W-1:0] w_a_r, w_a_i;
    logic [OUT_W-1:0] w_b_r, w_b_i;
    logic [OUT_W-1:0] w_g_r, w_g_i;
    logic [OUT_W-1:0] w_d_r, w_d_i;
    logic [OUT_W-1:0] w_h_r, w_h_i;
    logic [OUT_W-1:0] w_dl_in_r, w_dl_in_i;
    logic [OUT_W-1:0] w_out_r, w_out_i;
    logic [OUT_W-1:0] w_scl_r, w_scl_i;
    logic [CNT_W-1:0] w_out_tw;
    logic             w_emit;

    assign w_accept  = din_valid & r_din_ready;
    assign w_adv     = w_accept | (r_state == ST_DRAIN);
    assign w_wrap    = (r_cnt == c_cnt_max);
    assign w_cnt_nxt = w_wrap ? '0 : r_cnt + CNT_W'(1);

    // Sign-extend the input to the output width
    assign w_a_r = {din_r[DATA_W-1], din_r};
    assign w_a_i = {din_i[DATA_W-1], din_i};

    // Butterfly; the carry out of OUT_W is never significant because b is
    // an extended input or a difference of two extended inputs
    assign w_g_r = w_b_r + w_a_r;
    assign w_g_i = w_b_i + w_a_i;
    assign w_d_r = w_b_r - w_a_r;
    assign w_d_i = w_b_i - w_a_i;

    r2sdf_delay_line #(
        .WIDTH (OUT_W),
        .DEPTH (DELAY)
    ) u_delay_line (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (w_adv),
        .din_r  (w_dl_in_r),
        .din_i  (w_dl_in_i),
        .dout_r (w_b_r),
        .dout_i (w_b_i)
    );

    generate
        if (TRIV_ROT != 0) begin : g_rot
            logic [1:0]       w_k;
            logic [OUT_W-1:0] w_nb_r, w_nb_i;

            if (CNT_W >= 2) begin : g_k_wide
                assign w_k = r_cnt[1:0];
            end else begin : g_k_narrow
                assign w_k = {1'b0, r_cnt};
            end

            assign w_nb_r = '0 - w_b_r;
            assign w_nb_i = '0 - w_b_i;

            // Apply (-j)^k to the pending h as it leaves the delay line
            always_comb begin
                w_h_r = w_b_r;
                w_h_i = w_b_i;
                case (w_k)
                    ROT_NEG_J: begin w_h_r = w_b_i;  w_h_i = w_nb_r; end
                    ROT_NEG_1: begin w_h_r = w_nb_r; w_h_i = w_nb_i; end
                    ROT_POS_J: begin w_h_r = w_nb_i; w_h_i = w_b_r;  end
                    default:   begin w_h_r = w_b_r;  w_h_i = w_b_i;  end
                endcase
            end
        end else begin : g_norot
            assign w_h_r = w_b_r;
            assign w_h_i = w_b_i;
        end
    endgenerate

    // Output select, twiddle index and delay-line feed per phase
    always_comb begin
        w_emit    = 1'b0;
        w_out_r   = w_g_r;
        w_out_i   = w_g_i;
        w_out_tw  = '0;
        w_dl_in_r = w_a_r;
        w_dl_in_i = w_a_i;
        case (r_state)
            ST_RUN1: begin
                w_emit    = w_accept;
                w_dl_in_r = w_d_r;
                w_dl_in_i = w_d_i;
            end
            ST_RUN0: begin
                w_emit   = w_accept;
                w_out_r  = w_h_r;
                w_out_i  = w_h_i;
                w_out_tw = r_cnt;
            end
            ST_DRAIN: begin
                w_emit    = 1'b1;
                w_out_r   = w_h_r;
                w_out_i   = w_h_i;
                w_out_tw  = r_cnt;
                w_dl_in_r = '0;
                w_dl_in_i = '0;
            end
            default: ;
        endcase
    end

`ifdef R2SDF_SCALE_EN
    // (x+1)>>>1 rewritten as (x>>>1) + lsb, which cannot leave OUT_W
    assign w_scl_r = {w_out_r[OUT_W-1], w_out_r[OUT_W-1:1]} + OUT_W'(w_out_r[0]);
    assign w_scl_i = {w_out_i[OUT_W-1], w_out_i[OUT_W-1:1]} + OUT_W'(w_out_i[0]);
`else
    assign w_scl_r = w_out_r;
    assign w_scl_i = w_out_i;
`endif

    // Phase controller next-state; flush only counts on an idle input cycle
    // at a half-frame boundary
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = w_wrap ? ST_RUN1 : ST_LOAD;
            ST_LOAD:  if (w_accept && w_wrap) w_state_nxt = ST_RUN1;
            ST_RUN1:  if (w_accept && w_wrap) w_state_nxt = ST_RUN0;
            ST_RUN0: begin
                if (w_accept && w_wrap)
                    w_state_nxt = ST_RUN1;
                else if (!din_valid && flush && (r_cnt == '0))
                    w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (w_wrap) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Controller registers, with ready/busy registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_din_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_din_ready <= (w_state_nxt != ST_DRAIN);
            r_busy      <= (w_state_nxt != ST_IDLE);
            if (w_adv)
                r_cnt <= w_cnt_nxt;
        end
    end

    // Output registers; data and index hold while nothing is emitted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout_valid <= 1'b0;
            r_dout_r     <= '0;
            r_dout_i     <= '0;
            r_tw_idx     <= '0;
        end else begin
            r_dout_valid <= w_emit;
            if (w_emit) begin
                r_dout_r <= w_scl_r;
                r_dout_i <= w_scl_i;
                r_tw_idx <= w_out_tw;
            end
        end
    end

    assign din_ready  = r_din_ready;
    assign busy       = r_busy;
    assign dout_valid = r_dout_valid;
    assign dout_r     = r_dout_r;
    assign dout_i     = r_dout_i;
    assign tw_idx     = r_tw_idx;

endmodule
`default_nettype wire

// File: tb/tb_r2sdf_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_r2sdf_stage
//  Description : Directed self-checking bench for r2sdf_stage. Three
//                instances: DELAY=4 plain, DELAY=2 with trivial rotation,
//                DELAY=1. Expected values follow R2SDF_SCALE_EN if defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_r2sdf_stage;

    logic clk;
    logic rst_n;

    // DELAY=4 instance
    logic        v4, fl4, rdy4, ov4, busy4;
    logic [14:0] dr4, di4;
    logic [15:0] or4, oi4;
    logic [1:0]  tw4;
    // DELAY=2, TRIV_ROT=1 instance
    logic        v2, fl2, rdy2, ov2, busy2;
    logic [14:0] dr2, di2;
    logic [15:0] or2, oi2;
    logic [0:0]  tw2;
    // DELAY=1 instance
    logic        v1, fl1, rdy1, ov1, busy1;
    logic [14:0] dr1, di1;
    logic [15:0] or1, oi1;
    logic [0:0]  tw1;

    int n_chk;
    int n_pass;

    r2sdf_stage #(.DATA_W(15), .DELAY(4), .TRIV_ROT(0)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .din_valid(v4), .din_ready(rdy4),
        .din_r(dr4), .din_i(di4), .flush(fl4), .dout_valid(ov4),
        .dout_r(or4), .dout_i(oi4), .tw_idx(tw4), .busy(busy4));

    r2sdf_stage #(.DATA_W(15), .DELAY(2), .TRIV_ROT(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .din_valid(v2), .din_ready(rdy2),
        .din_r(dr2), .din_i(di2), .flush(fl2), .dout_valid(ov2),
        .dout_r(or2), .dout_i(oi2), .tw_idx(tw2), .busy(busy2));

    r2sdf_stage #(.DATA_W(15), .DELAY(1), .TRIV_ROT(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din_valid(v1), .din_ready(rdy1),
        .din_r(dr1), .din_i(di1), .flush(fl1), .dout_valid(ov1),
        .dout_r(or1), .dout_i(oi1), .tw_idx(tw1), .busy(busy1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs == exp_v)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    endtask

    function automatic int sc(input int x);
`ifdef R2SDF_SCALE_EN
        return (x + 1) >>> 1;
`else
        return x;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference for DELAY=4 stream: index i of frame 1..8 then 11..18
    function automatic int x4(input int i);
        return (i < 8) ? i + 1 : i + 3;
    endfunction
    function automatic int ev4(input int i);
        return (i >= 4) ? 1 : 0;
    endfunction
    function automatic int er4(input int i);
        if (i < 8)  return 2 * i - 2;   // g = (i-3) + (i+1)
        if (i < 12) return -4;          // h = b - a, a four steps ahead
        return 2 * i + 2;               // g = (i-1) + (i+3)
    endfunction
    function automatic int et4(input int i);
        return (i >= 8 && i < 12) ? i - 8 : 0;
    endfunction

    task automatic feed4(input int x, input int ev, input int er, input int etw);
        v4 = 1'b1; dr4 = 15'(x); di4 = '0; fl4 = 1'b0;
        tick();
        check_val("d4_valid", int'(ov4), ev);
        if (ev != 0) begin
            check_val("d4_re", int'($signed(or4)), sc(er));
            check_val("d4_tw", int'(tw4), etw);
        end
    endtask

    task automatic feed2(input int xr, input int xi, input int ev,
                         input int er, input int ei, input int etw);
        v2 = 1'b1; dr2 = 15'(xr); di2 = 15'(xi); fl2 = 1'b0;
        tick();
        check_val("d2_valid", int'(ov2), ev);
        if (ev != 0) begin
            check_val("d2_re", int'($signed(or2)), sc(er));
            check_val("d2_im", int'($signed(oi2)), sc(ei));
            check_val("d2_tw", int'(tw2), etw);
        end
    endtask

    task automatic feed1(input int x, input int ev, input int er);
        v1 = 1'b1; dr1 = 15'(x); di1 = '0; fl1 = 1'b0;
        tick();
        check_val("d1_valid", int'(ov1), ev);
        if (ev != 0) begin
            check_val("d1_re", int'($signed(or1)), sc(er));
            check_val("d1_tw", int'(tw1), 0);
        end
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst_n = 1'b1;
        v4 = 0; fl4 = 0; dr4 = '0; di4 = '0;
        v2 = 0; fl2 = 0; dr2 = '0; di2 = '0;
        v1 = 0; fl1 = 0; dr1 = '0; di1 = '0;
        #1 rst_n = 1'b0;
        #1;
        check_val("rst_valid", int'(ov4), 0);
        check_val("rst_re", int'(or4), 0);
        check_val("rst_tw", int'(tw4), 0);
        check_val("rst_busy", int'(busy4), 0);
        check_val("rst_ready", int'(rdy4), 1);
        #10 rst_n = 1'b1;

        // Frame 1..8 then 11..18, with an idle flush pulse at cnt==2
        feed4(x4(0), ev4(0), er4(0), et4(0));
        feed4(x4(1), ev4(1), er4(1), et4(1));
        v4 = 1'b0; fl4 = 1'b1;
        tick();
        fl4 = 1'b0;
        check_val("ign_flush_valid", int'(ov4), 0);
        check_val("ign_flush_ready", int'(rdy4), 1);
        check_val("ign_flush_busy", int'(busy4), 1);
        for (int i = 2; i < 16; i++)
            feed4(x4(i), ev4(i), er4(i), et4(i));
        check_val("d4_im", int'($signed(oi4)), 0);

        // Flush at cnt==0 in RUN0: four drain outputs of h = 11-15
        v4 = 1'b0; fl4 = 1'b1;
        tick();
        fl4 = 1'b0;
        check_val("flush_valid", int'(ov4), 0);
        check_val("flush_hold", int'($signed(or4)), sc(32));
        check_val("flush_ready", int'(rdy4), 0);
        for (int d = 0; d < 4; d++) begin
            tick();
            check_val("drain_valid", int'(ov4), 1);
            check_val("drain_re", int'($signed(or4)), sc(-4));
            check_val("drain_tw", int'(tw4), d);
            check_val("drain_ready", int'(rdy4), (d < 3) ? 0 : 1);
            check_val("drain_busy", int'(busy4), (d < 3) ? 1 : 0);
        end
        tick();
        check_val("idle_valid", int'(ov4), 0);

        // Reset in RUN1, then the first frame again
        for (int i = 0; i < 6; i++)
            feed4(x4(i), ev4(i), er4(i), et4(i));
        #3 rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", int'(ov4), 0);
        check_val("mid_rst_re", int'(or4), 0);
        check_val("mid_rst_busy", int'(busy4), 0);
        check_val("mid_rst_ready", int'(rdy4), 1);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 12; i++)
            feed4(x4(i), ev4(i), er4(i), et4(i));
        v4 = 1'b0;

        // Trivial rotation, DELAY=2
        feed2(1, 0, 0, 0, 0, 0);
        feed2(0, 0, 0, 0, 0, 0);
        feed2(3, 0, 1, 4, 0, 0);
        feed2(0, 2, 1, 0, 2, 0);
        feed2(7, 0, 1, -2, 0, 0);
        feed2(0, 0, 1, -2, 0, 1);
        v2 = 1'b0;

        // DELAY=1 pair 1, 2
        feed1(1, 0, 0);
        feed1(2, 1, 3);
        feed1(5, 1, -1);
        v1 = 1'b0;

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
